// File: rtl/apb_mem_responder.sv
// APB3 completer with a small word-addressed register memory, programmable per-transfer
// wait states, and PSLVERR on misaligned or out-of-range accesses.
module apb_mem_responder #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WAIT_W = 4
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [WAIT_W-1:0] wait_cycles,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [7:0]        err_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam logic [WIDX_W-1:0] DepthW = WIDX_W'(DEPTH);

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                setup;
    logic                complete;
    logic                addr_err;
    logic [WIDX_W-1:0]   word_idx;
    logic [IDX_W-1:0]    mem_idx;

    // Everything below works off the address captured at SETUP, never the live bus.
    assign word_idx = addr_q[ADDR_W-1:2];
    assign mem_idx  = addr_q[IDX_W+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || (word_idx >= DepthW);

    assign setup    = (state_q == StIdle) && psel && !penable;
    assign complete = (state_q == StAccess) && psel && penable && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    state_d = StAccess;
                    cnt_d   = wait_cycles;
                end
            end
            StAccess: begin
                if (!psel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (complete && addr_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
            if (setup) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (complete && write_q && !addr_err) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    assign pready    = complete;
    assign pslverr   = complete && addr_err;
    assign prdata    = (complete && !write_q && !addr_err) ? mem_q[mem_idx] : '0;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_apb_mem_responder.sv
// Directed bench for apb_mem_responder: stimulus pushes expected completions into a queue,
// a negedge monitor pops and compares them whenever pready is seen.
module tb_apb_mem_responder;

    logic        hclk;
    logic        hreset_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  wait_cycles;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    apb_mem_responder #(
        .ADDR_W(32),
        .DATA_W(32),
        .DEPTH (16),
        .WAIT_W(4)
    ) dut (
        .hclk       (hclk),
        .hreset_n   (hreset_n),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .wait_cycles(wait_cycles),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .err_count  (err_count)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completion must match the oldest expectation; idle cycles drive zeros.
    always @(negedge hclk) begin
        if (hreset_n) begin
            if (pready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_pready: got pready=1, required no completion");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check32("pslverr", {31'd0, pslverr}, {31'd0, e.err});
                    check32("prdata", prdata, e.rdata);
                end
            end else begin
                check32("idle_outputs", {prdata[30:0], pslverr}, 32'd0);
                check32("idle_prdata_msb", {31'd0, prdata[31]}, 32'd0);
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the completing edge so calls chain
    // back-to-back with no idle cycle.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input int waits, input logic exp_err, input logic [31:0] exp_rd);
        exp_t e;
        int   lat;
        bit   got;
        e.err   = exp_err;
        e.rdata = wr ? 32'd0 : exp_rd;
        exp_q.push_back(e);
        psel        = 1'b1;
        penable     = 1'b0;
        pwrite      = wr;
        paddr       = addr;
        pwdata      = data;
        wait_cycles = 4'(waits);
        @(posedge hclk);
        #1;
        penable     = 1'b1;
        paddr       = ~addr;
        pwdata      = ~data;
        wait_cycles = 4'd7;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge hclk);
            if (pready) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        check32("pready_seen", {31'd0, got}, 32'd1);
        check32("latency", lat, waits);
        @(posedge hclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] wdat [5];
        int          wwait [5];
        int          rwait [5];
        wdat  = '{32'h1111_0000, 32'h2222_1111, 32'h3333_2222, 32'h4444_3333, 32'h5555_4444};
        wwait = '{2, 0, 3, 1, 0};
        rwait = '{1, 3, 0, 2, 0};

        hreset_n    = 1'b0;
        psel        = 1'b0;
        penable     = 1'b0;
        pwrite      = 1'b0;
        paddr       = '0;
        pwdata      = '0;
        wait_cycles = '0;
        #2;
        check32("reset_pready", {31'd0, pready}, 32'd0);
        check32("reset_pslverr", {31'd0, pslverr}, 32'd0);
        check32("reset_prdata", prdata, 32'd0);
        check32("reset_err_count", {24'd0, err_count}, 32'd0);
        repeat (3) @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        @(posedge hclk);
        #1;

        // 1: zero-wait write then read
        apb_xfer(1'b1, 32'h04, 32'hDEAD_BEEF, 0, 1'b0, 32'd0);
        apb_xfer(1'b0, 32'h04, 32'd0, 0, 1'b0, 32'hDEAD_BEEF);

        // 2: read of a reset word with 3 wait states
        apb_xfer(1'b0, 32'h08, 32'd0, 3, 1'b0, 32'd0);

        // 3: out-of-range and misaligned writes
        apb_xfer(1'b1, 32'h40, 32'h1234_5678, 0, 1'b1, 32'd0);
        check32("err_count_range", {24'd0, err_count}, 32'd1);
        apb_xfer(1'b1, 32'h06, 32'h1234_5678, 1, 1'b1, 32'd0);
        check32("err_count_misalign", {24'd0, err_count}, 32'd2);
        apb_xfer(1'b0, 32'h00, 32'd0, 0, 1'b0, 32'd0);
        apb_xfer(1'b0, 32'h04, 32'd0, 0, 1'b0, 32'hDEAD_BEEF);
        apb_xfer(1'b0, 32'h06, 32'd0, 0, 1'b1, 32'd0);
        check32("err_count_read_err", {24'd0, err_count}, 32'd3);

        // 4: back-to-back writes then reads
        for (int i = 0; i < 5; i++) begin
            apb_xfer(1'b1, 32'(i * 4), wdat[i], wwait[i], 1'b0, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            apb_xfer(1'b0, 32'(i * 4), 32'd0, rwait[i], 1'b0, wdat[i]);
        end

        // penable without a proper SETUP must be ignored
        penable = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        psel = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge hclk);
        #1;

        // 5: reset in the middle of a waited write
        psel        = 1'b1;
        pwrite      = 1'b1;
        paddr       = 32'h0C;
        pwdata      = 32'hAAAA_5555;
        wait_cycles = 4'd2;
        @(posedge hclk);
        #1;
        penable = 1'b1;
        @(negedge hclk);
        #1;
        hreset_n = 1'b0;
        #1;
        check32("midreset_pready", {31'd0, pready}, 32'd0);
        check32("midreset_err_count", {24'd0, err_count}, 32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        @(posedge hclk);
        #1;
        apb_xfer(1'b0, 32'h0C, 32'd0, 0, 1'b0, 32'd0);
        apb_xfer(1'b0, 32'h00, 32'd0, 1, 1'b0, 32'd0);

        // 6: psel dropped during ACCESS aborts the write
        psel        = 1'b1;
        pwrite      = 1'b1;
        paddr       = 32'h14;
        pwdata      = 32'h5A5A_5A5A;
        wait_cycles = 4'd2;
        @(posedge hclk);
        #1;
        penable = 1'b1;
        @(posedge hclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge hclk);
        #1;
        check32("abort_err_count", {24'd0, err_count}, 32'd0);
        apb_xfer(1'b0, 32'h14, 32'd0, 0, 1'b0, 32'd0);

        // err_count saturates at 255
        for (int i = 0; i < 255; i++) begin
            apb_xfer(1'b1, 32'h06, 32'(i), 0, 1'b1, 32'd0);
        end
        check32("err_count_255", {24'd0, err_count}, 32'd255);
        apb_xfer(1'b0, 32'h80, 32'd0, 0, 1'b1, 32'd0);
        check32("err_count_sat", {24'd0, err_count}, 32'd255);

        repeat (3) @(posedge hclk);
        check32("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
